// File: rtl/seg_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : seg_decoder_if                                        |
// | Description: Display-bus tap and frame handshake bundle for        |
// |              seg_decoder. The master side drives the sampled       |
// |              display lines and the ack; the slave side (decoder)   |
// |              returns decoded frames.                               |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
interface seg_decoder_if;
    logic [6:0]  segmento;     // active-low segments, bit0=a .. bit6=g
    logic [3:0]  dig_n;        // active-low digit enables
    logic        ack;          // consumer accepts the held frame
    logic [15:0] digits;       // decoded frame, digit k in [4k+3:4k]
    logic [3:0]  err;          // per-digit unknown-pattern flags
    logic        frame_valid;  // a frame is held on digits/err
    logic        overrun;      // unacknowledged frame was overwritten

    modport master (
        output segmento,
        output dig_n,
        output ack,
        input  digits,
        input  err,
        input  frame_valid,
        input  overrun
    );

    modport slave (
        input  segmento,
        input  dig_n,
        input  ack,
        output digits,
        output err,
        output frame_valid,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : seg_decoder                                           |
// | Description: Recovers four BCD digits from a multiplexed,          |
// |              active-low seven-segment display bus. Inputs are      |
// |              synchronised and stability-filtered, patterns are     |
// |              decoded with an error flag, and complete frames are   |
// |              presented atomically through a valid/ack handshake.   |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module seg_decoder #(
    parameter int STABLE  = 4,     // identical samples needed to accept
    parameter int TIMEOUT = 1024   // idle cycles before a partial frame dies
) (
    input  logic          clk,
    input  logic          rst,
    seg_decoder_if.slave  bus
);

    localparam logic [3:0]  c_stable   = 4'(STABLE);
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_CAPT = 1'b1
    } state_t;

    // synchronizer stages
    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [3:0]  dig_s1_q, dig_s2_q;

    // stability filter
    logic [3:0]  run_q, run_d;
    logic        w_dig_ok;
    logic [1:0]  w_dig_idx;
    logic        acc_q;
    logic [6:0]  acc_seg_q;
    logic [1:0]  acc_idx_q;

    // pattern decode of the accepted sample
    logic [3:0]  w_code;
    logic        w_bad;

    // frame assembly and output holding
    state_t      state_q;
    logic [1:0]  want_q;
    logic [15:0] buf_q;
    logic [3:0]  buf_err_q;
    logic [15:0] tmo_q;
    logic [15:0] digits_q;
    logic [3:0]  err_q;
    logic        frame_valid_q;
    logic        overrun_q;

    // Two-flop synchronizers; reset to a blank display.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q <= 7'h7F;
            seg_s2_q <= 7'h7F;
            dig_s1_q <= 4'hF;
            dig_s2_q <= 4'hF;
        end else begin
            seg_s1_q <= bus.segmento;
            seg_s2_q <= seg_s1_q;
            dig_s1_q <= bus.dig_n;
            dig_s2_q <= dig_s1_q;
        end
    end

    // Run length of the sample about to enter s2; saturates so a run accepts once.
    always_comb begin
        run_d = run_q;
        if ({seg_s1_q, dig_s1_q} != {seg_s2_q, dig_s2_q}) begin
            run_d = 4'd1;
        end else if (run_q != c_stable) begin
            run_d = run_q + 4'd1;
        end
    end

    // Only a single active digit enable is a usable sample.
    always_comb begin
        w_dig_ok  = 1'b1;
        w_dig_idx = 2'd0;
        case (dig_s1_q)
            4'b1110: w_dig_idx = 2'd0;
            4'b1101: w_dig_idx = 2'd1;
            4'b1011: w_dig_idx = 2'd2;
            4'b0111: w_dig_idx = 2'd3;
            default: w_dig_ok  = 1'b0;
        endcase
    end

    // Accept strobe fires on the cycle the run first reaches STABLE samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= 4'd0;
            acc_q     <= 1'b0;
            acc_seg_q <= 7'h7F;
            acc_idx_q <= 2'd0;
        end else begin
            run_q     <= run_d;
            acc_q     <= w_dig_ok && (run_d == c_stable) && (run_q != c_stable);
            acc_seg_q <= seg_s1_q;
            acc_idx_q <= w_dig_idx;
        end
    end

    // Segment pattern back to BCD; 4'hF marks an unknown pattern.
    always_comb begin
        w_code = 4'hF;
        case (acc_seg_q)
            7'h40: w_code = 4'd0;
            7'h79: w_code = 4'd1;
            7'h24: w_code = 4'd2;
            7'h30: w_code = 4'd3;
            7'h19: w_code = 4'd4;
            7'h12: w_code = 4'd5;
            7'h02: w_code = 4'd6;
            7'h78: w_code = 4'd7;
            7'h00: w_code = 4'd8;
            7'h10: w_code = 4'd9;
            7'h18: w_code = 4'd9;
            default: w_code = 4'hF;
        endcase
        w_bad = (w_code == 4'hF);
    end

    // Frame FSM: collect digits 0..3 in order, commit atomically, handle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            want_q        <= 2'd0;
            buf_q         <= 16'h0000;
            buf_err_q     <= 4'h0;
            tmo_q         <= 16'h0000;
            digits_q      <= 16'h0000;
            err_q         <= 4'h0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (frame_valid_q && bus.ack) begin
                frame_valid_q <= 1'b0;
            end

            case (state_q)
                ST_SYNC: begin
                    if (acc_q && (acc_idx_q == 2'd0)) begin
                        buf_q[3:0]   <= w_code;
                        buf_err_q[0] <= w_bad;
                        want_q       <= 2'd1;
                        tmo_q        <= 16'h0000;
                        state_q      <= ST_CAPT;
                    end
                end

                ST_CAPT: begin
                    if (acc_q) begin
                        tmo_q <= 16'h0000;
                        if (acc_idx_q == want_q) begin
                            buf_q[{acc_idx_q, 2'b00} +: 4] <= w_code;
                            buf_err_q[acc_idx_q]           <= w_bad;
                            if (want_q == 2'd3) begin
                                // New frame wins over any held one; a same-cycle ack
                                // means the old frame was consumed, so no overrun.
                                digits_q      <= {w_code, buf_q[11:0]};
                                err_q         <= {w_bad, buf_err_q[2:0]};
                                frame_valid_q <= 1'b1;
                                overrun_q     <= frame_valid_q && !bus.ack;
                                state_q       <= ST_SYNC;
                            end else begin
                                want_q <= want_q + 2'd1;
                            end
                        end else if (acc_idx_q == 2'd0) begin
                            // Out-of-order digit 0 restarts the frame immediately.
                            buf_q[3:0]   <= w_code;
                            buf_err_q[0] <= w_bad;
                            want_q       <= 2'd1;
                        end else begin
                            state_q <= ST_SYNC;
                        end
                    end else if (tmo_q == c_tmo_last) begin
                        tmo_q   <= 16'h0000;
                        state_q <= ST_SYNC;
                    end else begin
                        tmo_q <= tmo_q + 16'h0001;
                    end
                end

                default: state_q <= ST_SYNC;
            endcase
        end
    end

    assign bus.digits      = digits_q;
    assign bus.err         = err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.overrun     = overrun_q;

endmodule
`default_nettype wire
